// File: rtl/pool_result_collector_if.sv
// Bus between CONV_TOP (pooled-result producer), the result collector and the
// downstream consumer of the drained frame.
//
// Drain handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high; once out_valid is raised, out_data and out_last stay
// stable until that transfer, and out_valid never drops without a transfer.
interface pool_result_collector_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic                 start;
  logic signed [DW-1:0] pooling_out;
  logic                 done_pooling;
  logic [AW-1:0]        addr;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 frame_done;
  logic                 busy;
  logic                 err_addr;
  logic                 err_overrun;
  logic [1:0]           state_dbg;

  // Producer / consumer side
  modport master (
    output start, pooling_out, done_pooling, addr, out_ready,
    input  out_data, out_valid, out_last, frame_done, busy,
           err_addr, err_overrun, state_dbg
  );

  // Collector side
  modport slave (
    input  start, pooling_out, done_pooling, addr, out_ready,
    output out_data, out_valid, out_last, frame_done, busy,
           err_addr, err_overrun, state_dbg
  );
endinterface

// File: rtl/pool_result_collector.sv
// Collects one pooled feature map (addressed writes from CONV_TOP), then
// drains it in raster order over a valid/ready stream.
module pool_result_collector #(
  parameter int IMG = 14,
  parameter int DW  = 16,
  parameter int AW  = 16
) (
  input logic                    clk,
  input logic                    rst,
  pool_result_collector_if.slave io
);
  localparam int DEPTH = (IMG / 2) * (IMG / 2);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_wr_cnt;
  logic [CW-1:0]        r_rd_ptr;
  logic signed [DW-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_frame_done;
  logic                 r_busy;
  logic                 r_err_addr;
  logic                 r_err_overrun;
  logic signed [DW-1:0] r_mem [0:DEPTH-1];

  logic                 w_addr_ok;
  logic                 w_wr_en;
  logic [AIW-1:0]       w_waddr;
  logic [AIW-1:0]       w_raddr;

  assign w_addr_ok = (io.addr < AW'(DEPTH));
  assign w_wr_en   = (r_state == S_COLLECT) && io.done_pooling && w_addr_ok;
  assign w_waddr   = io.addr[AIW-1:0];
  assign w_raddr   = r_rd_ptr[AIW-1:0];

  // Frame buffer: addressed writes during COLLECT only; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_waddr] <= io.pooling_out;
    end
  end

  // Control FSM with registered outputs; drain fetches one word, then holds it until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_cnt      <= '0;
      r_rd_ptr      <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_err_addr    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io.start) begin
            r_state       <= S_COLLECT;
            r_wr_cnt      <= '0;
            r_rd_ptr      <= '0;
            r_err_addr    <= 1'b0;
            r_err_overrun <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (io.done_pooling) begin
            if (w_addr_ok) begin
              r_wr_cnt <= r_wr_cnt + CW'(1);
              if (r_wr_cnt == CW'(DEPTH - 1)) begin
                r_frame_done <= 1'b1;
                r_state      <= S_DRAIN;
              end
            end else begin
              r_err_addr <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!r_out_valid) begin
            r_out_data  <= r_mem[w_raddr];
            r_out_last  <= (r_rd_ptr == CW'(DEPTH - 1));
            r_out_valid <= 1'b1;
          end else if (io.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_rd_ptr <= r_rd_ptr + CW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // A beat outside COLLECT is never stored; flag it even on the start cycle
      if (io.done_pooling && (r_state != S_COLLECT)) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign io.out_data    = r_out_data;
  assign io.out_valid   = r_out_valid;
  assign io.out_last    = r_out_last;
  assign io.frame_done  = r_frame_done;
  assign io.busy        = r_busy;
  assign io.err_addr    = r_err_addr;
  assign io.err_overrun = r_err_overrun;
  assign io.state_dbg   = r_state;
endmodule

// File: tb/tb_pool_result_collector.sv
// Bench for pool_result_collector: a table of whole-frame scenarios (write
// order, drain back-pressure, data range, error injection) plus hand-written
// reset and abort sequences.
module tb_pool_result_collector;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int IMG   = 14;
  localparam int DEPTH = 49;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_result_collector_if #(.DW(DW), .AW(AW)) io ();

  pool_result_collector #(.IMG(IMG), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int fd_count   = 0;

  logic [DW-1:0] exp_q [$];

  typedef struct {
    int order;          // 0 ascending, 1 descending, 2 stride-5 permutation
    int stall;          // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int base;           // data for addr a is base + a
    bit bad_addr;       // send addr=DEPTH with 0x7FFF before the frame
    bit overrun;        // send a beat in the middle of the drain
    bit exp_err_addr;
    bit exp_err_overrun;
  } frame_vec_t;

  frame_vec_t vecs [6];

  // frame_done pulse counter
  always @(negedge clk) begin
    if (io.frame_done === 1'b1) fd_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
  endtask

  task automatic send_beat(input int a, input int d);
    io.done_pooling = 1'b1;
    io.addr         = AW'(a);
    io.pooling_out  = DW'(d);
    @(negedge clk);
    io.done_pooling = 1'b0;
  endtask

  function automatic int beat_addr(input int order, input int k);
    if (order == 0) return k;
    if (order == 1) return DEPTH - 1 - k;
    return (k * 5) % DEPTH;
  endfunction

  // Drain everything, checking order, last flag, stall stability and end state
  task automatic drain(input int stall, input bit ovr, input bit exp_ea, input bit exp_eo);
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            cyc     = 0;
    bit            done    = 1'b0;
    bit            stalled = 1'b0;
    bit            rdy;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [DW-1:0] act_d;
    logic [DW-1:0] e;
    while (!done && cyc < 2000) begin
      act_d = io.out_data;
      if (stalled) begin
        chk("stall_valid", 32'(io.out_valid), 32'd1);
        chk("stall_data", 32'(act_d), 32'(held_d));
        chk("stall_last", 32'(io.out_last), 32'(held_l));
      end
      case (stall)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      stalled = 1'b0;
      if (io.out_valid === 1'b1) begin
        if (rdy) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL extra_word: got %0h expected no word", act_d);
            done = 1'b1;
          end else begin
            e = exp_q.pop_front();
            chk("drain_data", 32'(act_d), 32'(e));
            chk("drain_last", 32'(io.out_last), 32'(exp_q.size() == 0));
            if (io.out_last === 1'b1) done = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          held_d  = act_d;
          held_l  = io.out_last;
        end
      end
      io.out_ready    = rdy;
      io.done_pooling = ovr && (cyc == 6);
      io.addr         = AW'(40);
      io.pooling_out  = 16'sh1234;
      @(negedge clk);
      cyc++;
    end
    io.out_ready    = 1'b0;
    io.done_pooling = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d words left, expected drain to finish", exp_q.size());
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    chk("busy_after", 32'(io.busy), 32'd0);
    chk("valid_after", 32'(io.out_valid), 32'd0);
    chk("state_after", 32'(io.state_dbg), 32'd0);
    chk("frame_done_cnt", 32'(fd_count), 32'd1);
    chk("err_addr_end", 32'(io.err_addr), 32'(exp_ea));
    chk("err_overrun_end", 32'(io.err_overrun), 32'(exp_eo));
    exp_q.delete();
  endtask

  // One complete frame: start, optional bad beat, 49 beats, drain
  task automatic run_frame(input frame_vec_t v);
    int a;
    fd_count = 0;
    pulse_start();
    chk("busy_on_start", 32'(io.busy), 32'd1);
    chk("state_collect", 32'(io.state_dbg), 32'd1);
    chk("err_addr_clr", 32'(io.err_addr), 32'd0);
    chk("err_overrun_clr", 32'(io.err_overrun), 32'd0);
    if (v.bad_addr) begin
      send_beat(DEPTH, 32'h7FFF);
      chk("err_addr_set", 32'(io.err_addr), 32'd1);
    end
    for (int k = 0; k < DEPTH; k++) begin
      a = beat_addr(v.order, k);
      if (k == DEPTH - 1) chk("no_early_done", 32'(fd_count), 32'd0);
      send_beat(a, v.base + a);
    end
    chk("frame_done_pulse", 32'(io.frame_done), 32'd1);
    chk("state_drain", 32'(io.state_dbg), 32'd2);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(DW'(v.base + k));
    drain(v.stall, v.overrun, v.exp_err_addr, v.exp_err_overrun);
  endtask

  initial begin
    vecs[0] = '{order: 0, stall: 0, base: -24,    bad_addr: 0, overrun: 0, exp_err_addr: 0, exp_err_overrun: 0};
    vecs[1] = '{order: 1, stall: 0, base: -24,    bad_addr: 0, overrun: 0, exp_err_addr: 0, exp_err_overrun: 0};
    vecs[2] = '{order: 2, stall: 1, base: 32700,  bad_addr: 0, overrun: 0, exp_err_addr: 0, exp_err_overrun: 0};
    vecs[3] = '{order: 0, stall: 2, base: -32768, bad_addr: 0, overrun: 0, exp_err_addr: 0, exp_err_overrun: 0};
    vecs[4] = '{order: 0, stall: 0, base: 100,    bad_addr: 1, overrun: 0, exp_err_addr: 1, exp_err_overrun: 0};
    vecs[5] = '{order: 1, stall: 1, base: -7,     bad_addr: 0, overrun: 1, exp_err_addr: 0, exp_err_overrun: 1};

    io.start        = 1'b0;
    io.done_pooling = 1'b0;
    io.addr         = '0;
    io.pooling_out  = '0;
    io.out_ready    = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(io.out_valid), 32'd0);
    chk("rst_last", 32'(io.out_last), 32'd0);
    chk("rst_data", 32'(io.out_data), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_frame_done", 32'(io.frame_done), 32'd0);
    chk("rst_err_addr", 32'(io.err_addr), 32'd0);
    chk("rst_err_overrun", 32'(io.err_overrun), 32'd0);
    chk("rst_state", 32'(io.state_dbg), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // a beat while idle is flagged, not stored
    send_beat(5, 16'h0BAD);
    chk("idle_overrun", 32'(io.err_overrun), 32'd1);
    chk("idle_state", 32'(io.state_dbg), 32'd0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // reset mid-frame aborts; only the next frame's values come out
    pulse_start();
    for (int k = 0; k < 20; k++) send_beat(k, 1000 + k);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(io.busy), 32'd0);
    chk("abort_state", 32'(io.state_dbg), 32'd0);
    chk("abort_valid", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    chk("abort_idle_valid", 32'(io.out_valid), 32'd0);
    run_frame('{order: 2, stall: 0, base: -300, bad_addr: 0, overrun: 0, exp_err_addr: 0, exp_err_overrun: 0});

    // start during COLLECT is ignored: frame still needs all 49 beats
    fd_count = 0;
    pulse_start();
    for (int k = 0; k < 10; k++) send_beat(k, 7 * k);
    pulse_start();
    chk("start_in_collect", 32'(io.state_dbg), 32'd1);
    for (int k = 10; k < DEPTH; k++) send_beat(k, 7 * k);
    chk("late_frame_done", 32'(io.frame_done), 32'd1);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(DW'(7 * k));
    drain(0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
